// File: rtl/game_keys_pkg.sv
// Shared key indices and types for the game key conditioner.
package game_keys_pkg;

   localparam int unsigned N_KEYS       = 8;
   localparam int unsigned KEY_LAUNCH   = 0;
   localparam int unsigned KEY_RIGHT    = 1;
   localparam int unsigned KEY_LEFT     = 2;
   localparam int unsigned KEY_TORP_UD0 = 3;
   localparam int unsigned KEY_TORP_UD1 = 4;
   localparam int unsigned KEY_TGT_UD0  = 5;
   localparam int unsigned KEY_TGT_UD1  = 6;
   localparam int unsigned KEY_SPEED    = 7;

   typedef logic [1:0] speed_mode_t;

endpackage

// File: rtl/game_key_debounce.sv
// One key: 2-flop synchroniser, optional polarity flip, counter debounce and
// registered rising-edge pulse.
module game_key_debounce #(
   parameter int unsigned debounce_width = 20,
   parameter bit          raw_active_low = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   logic                      sync1_q, sync2_q;
   logic                      synced;
   logic                      deb_q, deb_d;
   logic                      deb_d1_q;
   logic                      rise_q;
   logic [debounce_width-1:0] cnt_q, cnt_d;

   assign synced = sync2_q ^ raw_active_low;

   // Flip only on the 2^W-th consecutive mismatch; any match restarts the count.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (synced != deb_q) begin
         if (cnt_q == '1) begin
            deb_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         deb_q    <= 1'b0;
         deb_d1_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         deb_d1_q <= deb_q;
         rise_q   <= deb_q & ~deb_d1_q;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o = deb_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/game_key_conditioner.sv
// Conditions raw board buttons into clean game key outputs and the speed mode.
// Optional speed-key autorepeat: define GAME_KEYS_AUTOREPEAT_EN.
module game_key_conditioner
   import game_keys_pkg::*;
#(
   parameter int unsigned debounce_width = 20,
   parameter bit          raw_active_low = 1'b0,
   parameter int unsigned repeat_width   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] raw_keys,
   output logic              launch_key,
   output logic [1:0]        left_right_keys,
   output logic [1:0]        up_down_keys,
   output logic [1:0]        up_down_keys_target,
   output speed_mode_t       target_speedup
);

   logic [N_KEYS-1:0] level;
   logic [N_KEYS-1:0] rise;
   logic              inc;
   speed_mode_t       speed_q, speed_d;
   logic              unused_keys;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      game_key_debounce #(
         .debounce_width (debounce_width),
         .raw_active_low (raw_active_low)
      ) u_debounce (
         .clk_i   (clk),
         .rst_ni  (rst),
         .raw_i   (raw_keys[k]),
         .level_o (level[k]),
         .rise_o  (rise[k])
      );
   end

   assign launch_key          = rise[KEY_LAUNCH];
   assign left_right_keys     = {level[KEY_LEFT], level[KEY_RIGHT]};
   assign up_down_keys        = {level[KEY_TORP_UD1], level[KEY_TORP_UD0]};
   assign up_down_keys_target = {level[KEY_TGT_UD1], level[KEY_TGT_UD0]};

   assign unused_keys = ^{rise[KEY_TGT_UD1:KEY_RIGHT], level[KEY_LAUNCH], level[KEY_SPEED]};

`ifdef GAME_KEYS_AUTOREPEAT_EN
   logic [repeat_width-1:0] rep_q, rep_d;
   logic                    rep_wrap;

   // Counter restarts on the press pulse so the first repeat lands a full period later.
   always_comb begin
      rep_d    = rep_q + 1'b1;
      rep_wrap = 1'b0;
      if (rise[KEY_SPEED] || !level[KEY_SPEED]) begin
         rep_d = '0;
      end else if (rep_q == '1) begin
         rep_wrap = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign inc = rise[KEY_SPEED] | rep_wrap;
`else
   assign inc = rise[KEY_SPEED];
`endif

   always_comb begin
      speed_d = speed_q;
      if (inc) begin
         speed_d = speed_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         speed_q <= 2'b00;
      end else begin
         speed_q <= speed_d;
      end
   end

   assign target_speedup = speed_q;

endmodule

// File: tb/tb_game_key_conditioner.sv
// Self-checking bench for game_key_conditioner (debounce_width=3, repeat_width=4).
module tb_game_key_conditioner;
   import game_keys_pkg::*;

   localparam int unsigned DW      = 3;
   localparam int unsigned RW      = 4;
   localparam bit          RAL     = 1'b0;
   localparam int unsigned DB_CYC  = 1 << DW;
   localparam int unsigned REP_CYC = 1 << RW;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  raw_keys = '0;
   logic        launch_key;
   logic [1:0]  left_right_keys, up_down_keys, up_down_keys_target;
   speed_mode_t target_speedup;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   game_key_conditioner #(
      .debounce_width (DW),
      .raw_active_low (RAL),
      .repeat_width   (RW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .raw_keys            (raw_keys),
      .launch_key          (launch_key),
      .left_right_keys     (left_right_keys),
      .up_down_keys        (up_down_keys),
      .up_down_keys_target (up_down_keys_target),
      .target_speedup      (target_speedup)
   );

   // Reference model: a key's clean level changes once its synchronised value
   // (raw delayed two cycles) has disagreed for DB_CYC consecutive cycles.
   bit          m_s1[8], m_s2[8], m_deb[8], m_deb_prev[8], m_pulse[8];
   int unsigned m_run[8];
   logic [1:0]  m_speed;
   int unsigned m_age;

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_deb_prev[k] = 0;
         m_pulse[k] = 0; m_run[k] = 0;
      end
      m_speed = 2'b00;
      m_age   = 0;
   endtask

   task automatic model_step(input logic [7:0] raw);
      bit nd, x;
      if (m_pulse[7]) begin
         m_speed = m_speed + 2'd1;
         m_age   = 0;
      end else if (m_deb[7]) begin
         m_age++;
`ifdef GAME_KEYS_AUTOREPEAT_EN
         if (m_age == REP_CYC) begin
            m_speed = m_speed + 2'd1;
            m_age   = 0;
         end
`endif
      end else begin
         m_age = 0;
      end
      for (int k = 0; k < 8; k++) begin
         x  = m_s2[k] ^ RAL;
         nd = m_deb[k];
         if (x != m_deb[k]) begin
            m_run[k]++;
            if (m_run[k] == DB_CYC) begin
               nd       = x;
               m_run[k] = 0;
            end
         end else begin
            m_run[k] = 0;
         end
         m_pulse[k]    = m_deb[k] & ~m_deb_prev[k];
         m_deb_prev[k] = m_deb[k];
         m_deb[k]      = nd;
         m_s2[k]       = m_s1[k];
         m_s1[k]       = raw[k];
      end
   endtask

   function automatic logic [8:0] dut_out();
      return {launch_key, left_right_keys, up_down_keys, up_down_keys_target, target_speedup};
   endfunction

   function automatic logic [8:0] model_out();
      return {m_pulse[0], m_deb[2], m_deb[1], m_deb[4], m_deb[3], m_deb[6], m_deb[5], m_speed};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Inputs are stable at the posedge; outputs are compared on the following negedge.
   task automatic tick();
      @(posedge clk);
      if (rst) model_step(raw_keys);
      else     model_reset();
      @(negedge clk);
      check("model", dut_out(), model_out());
   endtask

   typedef struct {
      logic [7:0]  raw;
      int unsigned n;
      logic [1:0]  lr, ud, tgt;
   } vec_t;

   vec_t        tbl[8];
   logic [1:0]  spd_seq[5];
   int unsigned incs;
   int unsigned idx;

   initial begin
      tbl[0] = '{8'h06,  9, 2'b00, 2'b00, 2'b00};
      tbl[1] = '{8'h06,  1, 2'b11, 2'b00, 2'b00};
      tbl[2] = '{8'h46,  9, 2'b11, 2'b00, 2'b00};
      tbl[3] = '{8'h46,  1, 2'b11, 2'b00, 2'b10};
      tbl[4] = '{8'h18,  9, 2'b11, 2'b00, 2'b10};
      tbl[5] = '{8'h18,  1, 2'b00, 2'b11, 2'b00};
      tbl[6] = '{8'h08, 10, 2'b00, 2'b01, 2'b00};
      tbl[7] = '{8'h00, 10, 2'b00, 2'b00, 2'b00};
      spd_seq[0] = 2'b01; spd_seq[1] = 2'b10; spd_seq[2] = 2'b11;
      spd_seq[3] = 2'b00; spd_seq[4] = 2'b01;

      // Asynchronous reset assertion before any clock edge, inputs toggling.
      model_reset();
      #1 rst = 1'b0;
      #1 check("rst_async", dut_out(), 9'd0);
      for (int i = 0; i < 6; i++) begin
         raw_keys = 8'($urandom);
         tick();
         check("rst_hold", dut_out(), 9'd0);
      end
      raw_keys = '0;
      rst = 1'b1;
      repeat (4) tick();

      // Clean press of launch: one pulse, 11 cycles after the edge.
      raw_keys[0] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         check("launch_clean", launch_key, (c == 11));
      end
      raw_keys[0] = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         check("launch_release", launch_key, 0);
      end

      // Bouncing launch, then a settled press.
      for (int c = 0; c < 30; c++) begin
         if (c % 3 == 0) raw_keys[0] = ~raw_keys[0];
         tick();
         check("launch_bounce", launch_key, 0);
      end
      raw_keys[0] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check("launch_after_bounce", launch_key, (c == 11));
      end
      raw_keys[0] = 1'b0;
      repeat (12) tick();

      // Seven-cycle glitch on right must not get through.
      raw_keys[1] = 1'b1;
      repeat (7) begin
         tick();
         check("glitch_lr", left_right_keys, 2'b00);
      end
      raw_keys[1] = 1'b0;
      repeat (13) begin
         tick();
         check("glitch_lr", left_right_keys, 2'b00);
      end

      // Five speed presses.
      for (int p = 0; p < 5; p++) begin
         raw_keys[7] = 1'b1;
         repeat (20) tick();
         check("speed_press", target_speedup, spd_seq[p]);
         raw_keys[7] = 1'b0;
         repeat (20) tick();
      end

      // Level outputs, including opposite keys together.
      for (int i = 0; i < 8; i++) begin
         raw_keys = tbl[i].raw;
         repeat (tbl[i].n) tick();
         check("tbl_lr",  left_right_keys,     tbl[i].lr);
         check("tbl_ud",  up_down_keys,        tbl[i].ud);
         check("tbl_tgt", up_down_keys_target, tbl[i].tgt);
      end

      // Long hold of speed key, starting from mode 01.
      raw_keys[7] = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
`ifdef GAME_KEYS_AUTOREPEAT_EN
         incs = (c >= 12) ? 1 + (c - 12) / REP_CYC : 0;
`else
         incs = (c >= 12) ? 1 : 0;
`endif
         check("speed_hold", target_speedup, 2'((1 + incs) % 4));
      end
      raw_keys[7] = 1'b0;
      repeat (12) tick();

      // Reset mid-hold, then re-debounce the still-held keys.
      raw_keys = 8'h81;
      repeat (15) tick();
      #2 rst = 1'b0;
      #1 check("rst_mid_async", dut_out(), 9'd0);
      repeat (3) tick();
      rst = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         check("launch_fresh", launch_key, (c == 11));
         check("speed_fresh", target_speedup, (c >= 12) ? 2'b01 : 2'b00);
      end
      raw_keys = '0;
      repeat (12) tick();

      // Random phase against the model.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            raw_keys = 8'($urandom);
         end else if ($urandom_range(0, 24) == 0) begin
            idx = $urandom_range(0, 7);
            raw_keys[idx] = ~raw_keys[idx];
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
